// File: rtl/pcie_intx_responder_if.sv
// Interrupt handshake and INTx message port between requester, responder and downstream.
// The responder takes the slave view; the requester/downstream side takes the master view.
interface pcie_intx_responder_if;
   logic       IRQ_REQ;
   logic       IRQ_ACK;
   logic       msg_valid;
   logic       msg_ready;
   logic       msg_assert;
   logic [1:0] msg_pin;

   modport slave (
      input  IRQ_REQ, msg_ready,
      output IRQ_ACK, msg_valid, msg_assert, msg_pin
   );

   modport master (
      output IRQ_REQ, msg_ready,
      input  IRQ_ACK, msg_valid, msg_assert, msg_pin
   );
endinterface

// File: rtl/pcie_intx_responder.sv
// Legacy INTx responder: turns IRQ_REQ level changes into Assert/Deassert_INTx messages
// and answers each serviced change with a one-cycle IRQ_ACK.
module pcie_intx_responder #(
   parameter int INTX_PIN    = 0,
   parameter int ACK_DELAY   = 2,
   parameter int MSG_TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   pcie_intx_responder_if.slave     bus,
   output logic                     intx_state,
   output logic                     busy,
   output logic [31:0]              assert_count,
   output logic [31:0]              deassert_count,
   output logic                     proto_err,
   output logic                     timeout_err,
   input  logic                     err_clear
);

   localparam int WW = $clog2(MSG_TIMEOUT);
   localparam logic [WW-1:0] WLAST = WW'(MSG_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SEND, DELAY, ACK} state_t;

   state_t        state_q;
   logic          req_q, start_q, target_q;
   logic          ack_q, valid_q, assert_q, intx_q, busy_q;
   logic          proto_q, tmo_q;
   logic [31:0]   acnt_q, dcnt_q;
   logic [WW-1:0] wcnt_q;
   logic [7:0]    dly_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         start_q  <= 1'b0;
         target_q <= 1'b0;
         ack_q    <= 1'b0;
         valid_q  <= 1'b0;
         assert_q <= 1'b0;
         intx_q   <= 1'b0;
         busy_q   <= 1'b0;
         proto_q  <= 1'b0;
         tmo_q    <= 1'b0;
         acnt_q   <= '0;
         dcnt_q   <= '0;
         wcnt_q   <= '0;
         dly_q    <= '0;
      end else begin
         req_q <= bus.IRQ_REQ;
         // Clears are written first so a same-cycle set below takes precedence.
         if (err_clear) begin
            proto_q <= 1'b0;
            tmo_q   <= 1'b0;
         end
         if (state_q != IDLE && req_q != start_q) proto_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (req_q != intx_q) begin
                  state_q  <= SEND;
                  target_q <= req_q;
                  start_q  <= req_q;
                  valid_q  <= 1'b1;
                  assert_q <= req_q;
                  busy_q   <= 1'b1;
                  wcnt_q   <= '0;
               end
            end
            SEND: begin
               if (valid_q && bus.msg_ready) begin
                  valid_q <= 1'b0;
                  intx_q  <= target_q;
                  if (target_q) acnt_q <= acnt_q + 32'd1;
                  else          dcnt_q <= dcnt_q + 32'd1;
                  if (ACK_DELAY == 0) begin
                     state_q <= ACK;
                     ack_q   <= 1'b1;
                  end else begin
                     state_q <= DELAY;
                     dly_q   <= 8'(ACK_DELAY);
                  end
               end else if (wcnt_q == WLAST) begin
                  // Abandon the message but still ack so the requester never stalls.
                  valid_q <= 1'b0;
                  tmo_q   <= 1'b1;
                  state_q <= ACK;
                  ack_q   <= 1'b1;
               end else begin
                  wcnt_q <= wcnt_q + 1'b1;
               end
            end
            DELAY: begin
               if (dly_q == 8'd1) begin
                  state_q <= ACK;
                  ack_q   <= 1'b1;
               end else begin
                  dly_q <= dly_q - 8'd1;
               end
            end
            ACK: begin
               ack_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.IRQ_ACK    = ack_q;
   assign bus.msg_valid  = valid_q;
   assign bus.msg_assert = assert_q;
   assign bus.msg_pin    = 2'(INTX_PIN);
   assign intx_state     = intx_q;
   assign busy           = busy_q;
   assign assert_count   = acnt_q;
   assign deassert_count = dcnt_q;
   assign proto_err      = proto_q;
   assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_pcie_intx_responder.sv
// Directed bench for pcie_intx_responder: main instance (ACK_DELAY=2, MSG_TIMEOUT=16) plus a
// zero-delay / minimum-timeout instance on pin INTD.
module tb_pcie_intx_responder;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pcie_intx_responder_if bus ();
   pcie_intx_responder_if bus0 ();

   logic        intx_state, busy, proto_err, timeout_err, err_clear;
   logic [31:0] assert_count, deassert_count;
   logic        intx_state0, busy0, proto_err0, timeout_err0, err_clear0;
   logic [31:0] assert_count0, deassert_count0;

   int tests = 0;
   int fails = 0;

   pcie_intx_responder #(.INTX_PIN(0), .ACK_DELAY(2), .MSG_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .intx_state(intx_state), .busy(busy),
      .assert_count(assert_count), .deassert_count(deassert_count),
      .proto_err(proto_err), .timeout_err(timeout_err), .err_clear(err_clear)
   );

   pcie_intx_responder #(.INTX_PIN(3), .ACK_DELAY(0), .MSG_TIMEOUT(2)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0),
      .intx_state(intx_state0), .busy(busy0),
      .assert_count(assert_count0), .deassert_count(deassert_count0),
      .proto_err(proto_err0), .timeout_err(timeout_err0), .err_clear(err_clear0)
   );

   // Returns at the negedge where IRQ_ACK is seen; a missing ack counts as a failure.
   task automatic wait_ack(input int budget, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (bus.IRQ_ACK === 1'b1) seen = 1'b1;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s ack_wait got no IRQ_ACK within %0d cycles", tag, budget);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if ({bus.msg_valid, bus.IRQ_ACK, intx_state, busy, proto_err, timeout_err} !== 6'b0) begin
         fails++;
         $display("FAIL reset_flags got %b exp 000000",
                  {bus.msg_valid, bus.IRQ_ACK, intx_state, busy, proto_err, timeout_err});
      end
      tests++;
      if (assert_count !== 32'd0 || deassert_count !== 32'd0) begin
         fails++;
         $display("FAIL reset_counts got %0d/%0d exp 0/0", assert_count, deassert_count);
      end
      tests++;
      if (bus0.msg_pin !== 2'd3) begin
         fails++;
         $display("FAIL msg_pin got %0d exp 3", bus0.msg_pin);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero_delay();
      @(negedge clk);
      bus0.IRQ_REQ = 1'b1;
      bus0.msg_ready = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         tests++;
         if (bus0.msg_valid !== (c == 2) || bus0.IRQ_ACK !== (c == 3)) begin
            fails++;
            $display("FAIL zd_assert c=%0d got v=%b a=%b exp v=%b a=%b",
                     c, bus0.msg_valid, bus0.IRQ_ACK, c == 2, c == 3);
         end
      end
      bus0.msg_ready = 1'b0;
      bus0.IRQ_REQ = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         tests++;
         if (bus0.msg_valid !== (c == 2 || c == 3) || bus0.IRQ_ACK !== (c == 4) ||
             timeout_err0 !== (c >= 4)) begin
            fails++;
            $display("FAIL zd_timeout c=%0d got v=%b a=%b t=%b", c, bus0.msg_valid,
                     bus0.IRQ_ACK, timeout_err0);
         end
      end
      tests++;
      if (intx_state0 !== 1'b1 || assert_count0 !== 32'd1 || deassert_count0 !== 32'd0) begin
         fails++;
         $display("FAIL zd_state got intx=%b a=%0d d=%0d exp 1/1/0",
                  intx_state0, assert_count0, deassert_count0);
      end
      bus0.msg_ready = 1'b1;
   endtask

   task automatic test_assert();
      bus.IRQ_REQ = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         tests++;
         if (bus.msg_valid !== (c == 2) || bus.IRQ_ACK !== (c == 5)) begin
            fails++;
            $display("FAIL t1_timing c=%0d got v=%b a=%b exp v=%b a=%b",
                     c, bus.msg_valid, bus.IRQ_ACK, c == 2, c == 5);
         end
         if (c == 2) begin
            tests++;
            if (bus.msg_assert !== 1'b1) begin
               fails++;
               $display("FAIL t1_msg_assert got %b exp 1", bus.msg_assert);
            end
         end
      end
      tests++;
      if (intx_state !== 1'b1 || assert_count !== 32'd1) begin
         fails++;
         $display("FAIL t1_state got intx=%b a=%0d exp 1/1", intx_state, assert_count);
      end
   endtask

   task automatic test_backpressure();
      bus.msg_ready = 1'b0;
      bus.IRQ_REQ = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         tests++;
         if (bus.msg_valid !== (c >= 2 && c <= 11) || bus.IRQ_ACK !== (c == 14)) begin
            fails++;
            $display("FAIL t2_timing c=%0d got v=%b a=%b", c, bus.msg_valid, bus.IRQ_ACK);
         end
         if (bus.msg_valid === 1'b1) begin
            tests++;
            if (bus.msg_assert !== 1'b0) begin
               fails++;
               $display("FAIL t2_msg_assert c=%0d got %b exp 0", c, bus.msg_assert);
            end
         end
         if (c == 11) bus.msg_ready = 1'b1;
      end
      tests++;
      if (intx_state !== 1'b0 || deassert_count !== 32'd1) begin
         fails++;
         $display("FAIL t2_state got intx=%b d=%0d exp 0/1", intx_state, deassert_count);
      end
   endtask

   task automatic test_timeout();
      bus.msg_ready = 1'b0;
      bus.IRQ_REQ = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         @(negedge clk);
         tests++;
         if (bus.msg_valid !== ((c >= 2 && c <= 17) || c >= 20) || bus.IRQ_ACK !== (c == 18) ||
             timeout_err !== (c >= 18) || intx_state !== 1'b0) begin
            fails++;
            $display("FAIL t3_timing c=%0d got v=%b a=%b t=%b i=%b", c, bus.msg_valid,
                     bus.IRQ_ACK, timeout_err, intx_state);
         end
      end
      bus.msg_ready = 1'b1;
      wait_ack(10, "t3_reissue");
      @(negedge clk);
      tests++;
      if (intx_state !== 1'b1 || assert_count !== 32'd2 || timeout_err !== 1'b1) begin
         fails++;
         $display("FAIL t3_state got intx=%b a=%0d t=%b exp 1/2/1",
                  intx_state, assert_count, timeout_err);
      end
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      tests++;
      if (timeout_err !== 1'b0) begin
         fails++;
         $display("FAIL t3_err_clear got %b exp 0", timeout_err);
      end
   endtask

   task automatic test_proto_err();
      bus.IRQ_REQ = 1'b0;
      wait_ack(20, "t4_prep");
      repeat (2) @(negedge clk);
      bus.IRQ_REQ = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         tests++;
         if (bus.msg_valid !== (c == 2 || c == 7) || bus.IRQ_ACK !== (c == 5 || c == 10) ||
             proto_err !== (c >= 5)) begin
            fails++;
            $display("FAIL t4_timing c=%0d got v=%b a=%b p=%b", c, bus.msg_valid,
                     bus.IRQ_ACK, proto_err);
         end
         if (c == 2 || c == 7) begin
            tests++;
            if (bus.msg_assert !== (c == 2)) begin
               fails++;
               $display("FAIL t4_msg_assert c=%0d got %b exp %b", c, bus.msg_assert, c == 2);
            end
         end
         if (c == 3) bus.IRQ_REQ = 1'b0;
      end
      tests++;
      if (assert_count !== 32'd3 || deassert_count !== 32'd3 || intx_state !== 1'b0) begin
         fails++;
         $display("FAIL t4_counts got a=%0d d=%0d i=%b exp 3/3/0",
                  assert_count, deassert_count, intx_state);
      end
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      tests++;
      if (proto_err !== 1'b0) begin
         fails++;
         $display("FAIL t4_err_clear got %b exp 0", proto_err);
      end
   endtask

   task automatic test_glitch();
      @(negedge clk);
      bus.IRQ_REQ = 1'b1;
      #2 bus.IRQ_REQ = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         tests++;
         if (bus.msg_valid !== 1'b0 || bus.IRQ_ACK !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL glitch c=%0d got v=%b a=%b b=%b exp 0/0/0",
                     c, bus.msg_valid, bus.IRQ_ACK, busy);
         end
      end
   endtask

   task automatic test_reset_in_send();
      bus.msg_ready = 1'b0;
      bus.IRQ_REQ = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      tests++;
      if ({bus.msg_valid, bus.IRQ_ACK, intx_state, busy} !== 4'b0 ||
          assert_count !== 32'd0 || deassert_count !== 32'd0) begin
         fails++;
         $display("FAIL t5_async got v=%b a=%b i=%b b=%b ac=%0d dc=%0d", bus.msg_valid,
                  bus.IRQ_ACK, intx_state, busy, assert_count, deassert_count);
      end
      @(negedge clk);
      bus.IRQ_REQ = 1'b0;
      bus.msg_ready = 1'b1;
      reset = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         tests++;
         if (bus.IRQ_ACK !== 1'b0 || bus.msg_valid !== 1'b0) begin
            fails++;
            $display("FAIL t5_quiet c=%0d got v=%b a=%b exp 0/0", c, bus.msg_valid, bus.IRQ_ACK);
         end
      end
      bus.IRQ_REQ = 1'b1;
      wait_ack(10, "t5_after");
      tests++;
      if (assert_count !== 32'd1) begin
         fails++;
         $display("FAIL t5_count got %0d exp 1", assert_count);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      reset = 1'b1;
      bus.IRQ_REQ = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
         bus.IRQ_REQ = ~bus.IRQ_REQ;
         wait_ack(12, "t6_ack");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (2) @(negedge clk);
      tests++;
      if (assert_count + deassert_count !== 32'd1000 || assert_count !== 32'd500) begin
         fails++;
         $display("FAIL t6_counts got a=%0d d=%0d exp 500/500", assert_count, deassert_count);
      end
      tests++;
      if (proto_err !== 1'b0 || timeout_err !== 1'b0) begin
         fails++;
         $display("FAIL t6_errors got p=%b t=%b exp 0/0", proto_err, timeout_err);
      end
   endtask

   initial begin
      reset          = 1'b1;
      bus.IRQ_REQ    = 1'b0;
      bus.msg_ready  = 1'b1;
      bus0.IRQ_REQ   = 1'b0;
      bus0.msg_ready = 1'b1;
      err_clear      = 1'b0;
      err_clear0     = 1'b0;
      test_reset();
      test_zero_delay();
      test_assert();
      test_backpressure();
      test_timeout();
      test_proto_err();
      test_glitch();
      test_reset_in_send();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
